// File: rtl/iob_cache_rep_ctrl_pkg.sv
// iob_cache_rep_ctrl_pkg: FSM state type for iob_cache_rep_ctrl (FLUSH only with IOB_CACHE_REP_CTRL_FLUSH_EN)
`include "iob_cache_rep_ctrl.vh"
package iob_cache_rep_ctrl_pkg;
    localparam int ST_W = 3;
    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = `IOB_CACHE_REP_CTRL_ST_IDLE,
        ST_FILL_REQ  = `IOB_CACHE_REP_CTRL_ST_FILL_REQ,
        ST_FILL_WAIT = `IOB_CACHE_REP_CTRL_ST_FILL_WAIT,
        ST_COMMIT    = `IOB_CACHE_REP_CTRL_ST_COMMIT
`ifdef IOB_CACHE_REP_CTRL_FLUSH_EN
        , ST_FLUSH   = `IOB_CACHE_REP_CTRL_ST_FLUSH
`endif
    } state_t;
endpackage

// File: rtl/iob_cache_rep_ctrl.vh
// iob_cache_rep_ctrl.vh: shared 3-bit FSM state encodings for the replacement controller and its bench
`ifndef IOB_CACHE_REP_CTRL_VH
`define IOB_CACHE_REP_CTRL_VH
`define IOB_CACHE_REP_CTRL_ST_IDLE      3'd0
`define IOB_CACHE_REP_CTRL_ST_FILL_REQ  3'd1
`define IOB_CACHE_REP_CTRL_ST_FILL_WAIT 3'd2
`define IOB_CACHE_REP_CTRL_ST_COMMIT    3'd3
`define IOB_CACHE_REP_CTRL_ST_FLUSH     3'd4
`endif

// File: rtl/iob_cache_rep_ctrl_sweep.sv
// iob_cache_rep_ctrl_sweep: set counter for policy flush; ports clk_i/arst_n_i/cke_i, start_i (clear), step_i (advance), addr_o (current set), done_o (last set)
module iob_cache_rep_ctrl_sweep #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         cke_i,
    input  logic         start_i,
    input  logic         step_i,
    output logic [W-1:0] addr_o,
    output logic         done_o
);
    logic [W-1:0] addr_q, addr_d;
    always_comb addr_d = start_i ? '0 : step_i ? addr_q + W'(1) : addr_q;
    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) addr_q <= '0;
        else if (cke_i) addr_q <= addr_d;
    assign addr_o = addr_q;
    assign done_o = &addr_q;
endmodule

// File: rtl/iob_cache_rep_ctrl.sv
// iob_cache_rep_ctrl: cache replacement-policy controller (hit update, miss fill/commit, optional flush via IOB_CACHE_REP_CTRL_FLUSH_EN); ports: req_* access in, pol_* policy write out, fill_* back-end handshake, flush_i/busy_o
module iob_cache_rep_ctrl
    import iob_cache_rep_ctrl_pkg::*;
#(
    parameter int N_WAYS      = 8,
    parameter int SET_INDEX_W = 4,
    parameter int NWAYS_W     = $clog2(N_WAYS)
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [SET_INDEX_W-1:0] req_addr_i,
    input  logic [N_WAYS-1:0]      way_hit_i,
    input  logic [NWAYS_W-1:0]     victim_bin_i,
    output logic                   pol_we_o,
    output logic [SET_INDEX_W-1:0] pol_addr_o,
    output logic [N_WAYS-1:0]      pol_way_hit_o,
    output logic                   pol_clr_o,
    output logic                   fill_valid_o,
    input  logic                   fill_ready_i,
    output logic [NWAYS_W-1:0]     fill_way_o,
    output logic [SET_INDEX_W-1:0] fill_addr_o,
    input  logic                   fill_done_i,
    input  logic                   flush_i,
    output logic                   busy_o
);
    state_t                   state_q, state_d;
    logic [SET_INDEX_W-1:0]   set_q, set_d;
    logic [NWAYS_W-1:0]       victim_q, victim_d;
    logic                     flush_pend_q;
`ifdef IOB_CACHE_REP_CTRL_FLUSH_EN
    logic                     flush_pend_d, sweep_start, sweep_done;
    logic [SET_INDEX_W-1:0]   sweep_addr;
    iob_cache_rep_ctrl_sweep #(.W(SET_INDEX_W)) u_sweep (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .start_i(sweep_start), .step_i(state_q == ST_FLUSH),
        .addr_o(sweep_addr), .done_o(sweep_done)
    );
    // a flush_i arriving on the entry cycle re-arms the pending flag for another sweep
    always_comb flush_pend_d = flush_i | (flush_pend_q & ~sweep_start);
    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) flush_pend_q <= 1'b0;
        else if (cke_i) flush_pend_q <= flush_pend_d;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush_pend_q = 1'b0;
`endif
    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        victim_d      = victim_q;
        req_ready_o   = 1'b0;
        pol_we_o      = 1'b0;
        pol_way_hit_o = '0;
        pol_clr_o     = 1'b0;
        pol_addr_o    = set_q;
        fill_valid_o  = 1'b0;
`ifdef IOB_CACHE_REP_CTRL_FLUSH_EN
        sweep_start   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready_o = ~flush_pend_q;
                pol_addr_o  = req_addr_i;
`ifdef IOB_CACHE_REP_CTRL_FLUSH_EN
                if (flush_pend_q) begin
                    state_d     = ST_FLUSH;
                    sweep_start = 1'b1;
                end else
`endif
                if (req_valid_i) begin
                    if (|way_hit_i) begin
                        pol_we_o      = 1'b1;
                        pol_way_hit_o = way_hit_i;
                    end else begin
                        state_d  = ST_FILL_REQ;
                        set_d    = req_addr_i;
                        victim_d = victim_bin_i;
                    end
                end
            end
            ST_FILL_REQ: begin
                fill_valid_o = 1'b1;
                state_d      = fill_ready_i ? ST_FILL_WAIT : ST_FILL_REQ;
            end
            ST_FILL_WAIT: state_d = fill_done_i ? ST_COMMIT : ST_FILL_WAIT;
            ST_COMMIT: begin
                pol_we_o      = 1'b1;
                pol_way_hit_o = N_WAYS'(1) << victim_q;
                state_d       = ST_IDLE;
            end
`ifdef IOB_CACHE_REP_CTRL_FLUSH_EN
            ST_FLUSH: begin
                pol_we_o   = 1'b1;
                pol_clr_o  = 1'b1;
                pol_addr_o = sweep_addr;
                state_d    = sweep_done ? ST_IDLE : ST_FLUSH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) begin
            state_q  <= ST_IDLE;
            set_q    <= '0;
            victim_q <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            set_q    <= set_d;
            victim_q <= victim_d;
        end
    assign fill_way_o  = victim_q;
    assign fill_addr_o = set_q;
    assign busy_o      = (state_q != ST_IDLE) | flush_pend_q;
endmodule
